// File: rtl/wb_decoder2_if.sv
// Wishbone B3 bus bundle for one point-to-point link (master side drives the request).
// Field map: adr/dat_wr/sel/we/cti/bte/lock/cyc/stb = *_ADR/DAT/SEL/WE/CTI/BTE/LOCK/CYC/STB, dat_rd/ack/err/rty = responses.
interface wb_decoder2_if;
   logic [31:0] adr;
   logic [31:0] dat_wr;
   logic [3:0]  sel;
   logic        we;
   logic [2:0]  cti;
   logic [1:0]  bte;
   logic        lock;
   logic        cyc;
   logic        stb;
   logic [31:0] dat_rd;
   logic        ack;
   logic        err;
   logic        rty;

   modport master (
      output adr, dat_wr, sel, we, cti, bte, lock, cyc, stb,
      input  dat_rd, ack, err, rty
   );

   modport slave (
      input  adr, dat_wr, sel, we, cti, bte, lock, cyc, stb,
      output dat_rd, ack, err, rty
   );
endinterface

// File: rtl/wb_decoder2.sv
// One-master to two-slave Wishbone decoder; latches the slave choice per cycle and
// terminates unmapped or unresponsive accesses with ERR.
module wb_decoder2 #(
   parameter logic [31:0] S0_BASE = 32'h8000_0000,
   parameter logic [31:0] S0_MASK = 32'hFFFF_F000,
   parameter logic [31:0] S1_BASE = 32'h8000_1000,
   parameter logic [31:0] S1_MASK = 32'hFFFF_F000,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   wb_decoder2_if.slave  wbm,
   wb_decoder2_if.master wbs0,
   wb_decoder2_if.master wbs1,
   output logic [2:0]    state_dbg
);

   // Handshake: a request is live while cyc & stb and must be held until the cycle
   // in which ack, err or rty is high; that cycle completes the beat.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      SLV0 = 3'd1,
      SLV1 = 3'd2,
      DERR = 3'd3,
      TOUT = 3'd4
   } state_t;

   localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic        hit0, hit1;
   logic        term, cti_end, wd_expire;

   assign hit0      = (wbm.adr & S0_MASK) == S0_BASE;
   assign hit1      = (wbm.adr & S1_MASK) == S1_BASE;
   assign cti_end   = (wbm.cti == 3'b000) || (wbm.cti == 3'b111);
   assign term      = (state == SLV0) ? (wbs0.ack | wbs0.err | wbs0.rty) :
                      (state == SLV1) ? (wbs1.ack | wbs1.err | wbs1.rty) : 1'b0;
   assign wd_expire = (TIMEOUT != 0) && wbm.stb && !term && (cnt == TO_LAST);
   assign state_dbg = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      case (state)
         IDLE: begin
            if (wbm.cyc && wbm.stb) begin
               if (hit0)      state_nxt = SLV0;
               else if (hit1) state_nxt = SLV1;
               else           state_nxt = DERR;
            end
         end
         SLV0, SLV1: begin
            // Bursts and locked sequences keep the selection until a final, unlocked beat.
            if (!wbm.cyc)                        state_nxt = IDLE;
            else if (term && cti_end && !wbm.lock) state_nxt = IDLE;
            else if (wd_expire)                  state_nxt = TOUT;
            else if (wbm.stb && !term)           cnt_nxt   = cnt + 16'd1;
         end
         DERR, TOUT: state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   always_comb begin
      wbs0.adr    = '0;
      wbs0.dat_wr = '0;
      wbs0.sel    = '0;
      wbs0.we     = 1'b0;
      wbs0.cti    = '0;
      wbs0.bte    = '0;
      wbs0.lock   = 1'b0;
      wbs0.cyc    = 1'b0;
      wbs0.stb    = 1'b0;
      wbs1.adr    = '0;
      wbs1.dat_wr = '0;
      wbs1.sel    = '0;
      wbs1.we     = 1'b0;
      wbs1.cti    = '0;
      wbs1.bte    = '0;
      wbs1.lock   = 1'b0;
      wbs1.cyc    = 1'b0;
      wbs1.stb    = 1'b0;
      wbm.dat_rd  = '0;
      wbm.ack     = 1'b0;
      wbm.err     = 1'b0;
      wbm.rty     = 1'b0;
      case (state)
         SLV0: begin
            wbs0.adr    = wbm.adr;
            wbs0.dat_wr = wbm.dat_wr;
            wbs0.sel    = wbm.sel;
            wbs0.we     = wbm.we;
            wbs0.cti    = wbm.cti;
            wbs0.bte    = wbm.bte;
            wbs0.lock   = wbm.lock;
            wbs0.cyc    = wbm.cyc;
            wbs0.stb    = wbm.stb;
            wbm.dat_rd  = wbs0.dat_rd;
            wbm.ack     = wbs0.ack;
            wbm.err     = wbs0.err;
            wbm.rty     = wbs0.rty;
         end
         SLV1: begin
            wbs1.adr    = wbm.adr;
            wbs1.dat_wr = wbm.dat_wr;
            wbs1.sel    = wbm.sel;
            wbs1.we     = wbm.we;
            wbs1.cti    = wbm.cti;
            wbs1.bte    = wbm.bte;
            wbs1.lock   = wbm.lock;
            wbs1.cyc    = wbm.cyc;
            wbs1.stb    = wbm.stb;
            wbm.dat_rd  = wbs1.dat_rd;
            wbm.ack     = wbs1.ack;
            wbm.err     = wbs1.err;
            wbm.rty     = wbs1.rty;
         end
         DERR:    wbm.err = wbm.stb;
         TOUT:    wbm.err = 1'b1;
         default: ;
      endcase
   end

endmodule
